key_press_classifier: RTL and testbench
=======================================

// Module: key_press_classifier
// PURPOSE
// - Sits directly downstream of the key debouncer: consumes its clean, active-high "key held" level.
// - Turns that level into one-cycle user events: short press, long press and (optionally) auto-repeat.
// - The watch mode/set FSM uses these events to step fields, enter set mode and scroll values.
// PARAMETERS
// - LONG_CYCLES    default 50_000_000  press length, in clk_i cycles, that qualifies as long (1 s @ 50 MHz); must be >= 2
// - REPEAT_CYCLES  default 10_000_000  auto-repeat period in clk_i cycles while held after long; must be >= 2
// - CNT_W          default 32          hold counter width; must hold max(LONG_CYCLES, REPEAT_CYCLES)-1
// PORTS
// - clk_i     in   1  system clock; single clock domain
// - rst_i     in   1  synchronous, active-high reset
// - debkey_i  in   1  debounced key level from the debouncer; 1 = pressed
// - short_o   out  1  one-cycle pulse: key released before reaching long
// - long_o    out  1  one-cycle pulse: key held for LONG_CYCLES
// - repeat_o  out  1  one-cycle pulse every REPEAT_CYCLES while held after long
// - held_o    out  1  level: high while in HELD (long already reported)
// BEHAVIOUR
// - Reset: state=IDLE, cnt=0; short_o, long_o, repeat_o, held_o all 0 from the first edge with rst_i=1.
// - rst_i has priority over every transition; reset mid-press discards the press and emits no event.
// - All outputs are registered; each pulse is high for exactly the cycle after the edge that takes the transition.
// - FSM states: IDLE, PRESS, HELD.
// - IDLE
//   - debkey_i=1 -> PRESS, cnt<=0.
//   - A key still high after reset counts as a new press.
// - PRESS
//   - debkey_i=0 -> IDLE, short_o<=1.
//   - else cnt==LONG_CYCLES-1 -> HELD, long_o<=1, cnt<=0.
//   - else cnt<=cnt+1.
//   - Release and threshold on the same edge: release wins, so short_o fires and long_o does not.
// - HELD
//   - debkey_i=0 -> IDLE with no pulse; held_o<=0.
//   - else count as described under CONFIGURATION.
// - Latency
//   - short_o: 1 cycle after the edge sampling debkey_i=0.
//   - long_o: LONG_CYCLES edges after the edge that entered PRESS.
// - Counter is unsigned CNT_W bits; compare with equality only.
//   - It never wraps, because it is cleared at each threshold.
// - At most one of short_o/long_o/repeat_o is high in any cycle.
// CONFIGURATION
// - Macro KEY_AUTOREPEAT_EN.
// - Defined: in HELD, cnt==REPEAT_CYCLES-1 -> repeat_o<=1, cnt<=0; else cnt<=cnt+1.
// - Undefined:
//   - HELD does not count; cnt holds 0.
//   - repeat_o is driven constant 0.
//   - REPEAT_CYCLES is unused.
// STRUCTURE
// - Shared package key_pkg:
//   - typedef enum logic [1:0] {KEY_IDLE, KEY_PRESS, KEY_HELD} key_state_t;
//   - default cycle constants for the 50 MHz board.
//   - The mode FSM reuses these.
// - No sub-module: FSM, counter and output registers are one always_ff block plus next-state logic.
// TESTING (LONG_CYCLES=10, REPEAT_CYCLES=4)
// - Hold rst_i=1 for 3 cycles, debkey_i=1 -> all outputs 0, state IDLE.
//   - Key high after rst_i drops -> PRESS on the next edge.
// - debkey_i=1 for 3 cycles, then 0 -> exactly one short_o pulse; long_o, repeat_o, held_o stay 0.
// - debkey_i=1 held 25 cycles with KEY_AUTOREPEAT_EN:
//   - long_o once, 10 edges after PRESS entry; held_o rises with it.
//   - then repeat_o every 4 cycles (3 pulses).
//   - release -> no short_o, held_o falls.
// - Release on the exact edge where cnt==9 -> short_o pulse; no long_o; held_o stays 0.
// - Assert rst_i for 1 cycle while in HELD -> all outputs 0 next cycle, state IDLE, no short_o on later release.
// - Same 25-cycle hold without KEY_AUTOREPEAT_EN -> long_o once; repeat_o constantly 0.

Source files
------------

// File: rtl/key_pkg.sv
// Shared key-handling definitions: FSM state encoding and the default
// cycle constants for the 50 MHz board. The watch mode FSM imports these too.
package key_pkg;

    typedef enum logic [1:0] {
        KEY_IDLE,
        KEY_PRESS,
        KEY_HELD
    } key_state_t;

    // 1 s long-press threshold at 50 MHz
    localparam int KEY_LONG_CYCLES   = 50_000_000;
    // 200 ms auto-repeat period at 50 MHz
    localparam int KEY_REPEAT_CYCLES = 10_000_000;
    // Hold counter width; covers both constants above
    localparam int KEY_CNT_W         = 32;

endpackage : key_pkg

// File: rtl/key_press_classifier.sv
// key_press_classifier: turns the debounced key level into one-cycle
// short / long / auto-repeat events plus a "held" level.
// Build option: define KEY_AUTOREPEAT_EN to emit repeat_o pulses while the key
// stays held after a long press; otherwise repeat_o is tied low.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// KEY_IDLE  | key released, waiting for a press
// KEY_PRESS | key down, counting toward the long-press threshold
// KEY_HELD  | long press already reported, key still down
import key_pkg::*;

module key_press_classifier #(
    parameter int LONG_CYCLES   = KEY_LONG_CYCLES,
    parameter int REPEAT_CYCLES = KEY_REPEAT_CYCLES,
    parameter int CNT_W         = KEY_CNT_W
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic debkey_i,
    output logic short_o,
    output logic long_o,
    output logic repeat_o,
    output logic held_o
);

    // Reject configurations where a threshold could never be reached cleanly.
    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("key_press_classifier: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    key_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              short_q, short_d;
    logic              long_q, long_d;
    logic              held_q, held_d;

`ifdef KEY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic              repeat_q, repeat_d;
`endif

    // Next-state, counter and pulse decode; release always beats the threshold.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        repeat_d = 1'b0;
`endif
        case (state_q)
            KEY_IDLE: begin
                if (debkey_i) begin
                    state_d = KEY_PRESS;
                    cnt_d   = '0;
                end
            end
            KEY_PRESS: begin
                if (!debkey_i) begin
                    state_d = KEY_IDLE;
                    short_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = KEY_HELD;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            KEY_HELD: begin
                if (!debkey_i) begin
                    state_d = KEY_IDLE;
                end else begin
`ifdef KEY_AUTOREPEAT_EN
                    if (cnt_q == REPEAT_LAST) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = KEY_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == KEY_HELD);
    end

    // State, counter and registered outputs; reset discards any press in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= KEY_IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            held_q   <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            repeat_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            held_q   <= held_d;
`ifdef KEY_AUTOREPEAT_EN
            repeat_q <= repeat_d;
`endif
        end
    end

    assign short_o = short_q;
    assign long_o  = long_q;
    assign held_o  = held_q;
`ifdef KEY_AUTOREPEAT_EN
    assign repeat_o = repeat_q;
`else
    assign repeat_o = 1'b0;
`endif

endmodule : key_press_classifier

// File: tb/tb_key_press_classifier.sv
// Directed bench for key_press_classifier with LONG_CYCLES=10, REPEAT_CYCLES=4.
// Expectations adapt to whether KEY_AUTOREPEAT_EN is defined for the build.
import key_pkg::*;

module tb_key_press_classifier;

    localparam int LONG   = 10;
    localparam int REPEAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic debkey = 1'b0;
    logic short_p, long_p, repeat_p, held;

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Event tallies over a stimulus window
    int tick_idx, n_short, n_long, n_rep, n_held_hi, n_multi;
    int first_long_at, first_rep_at, first_short_at;
    logic held_at_long;

    key_press_classifier #(
        .LONG_CYCLES  (LONG),
        .REPEAT_CYCLES(REPEAT),
        .CNT_W        (8)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .debkey_i(debkey),
        .short_o (short_p),
        .long_o  (long_p),
        .repeat_o(repeat_p),
        .held_o  (held)
    );

    always #5 clk = ~clk;

`ifdef KEY_AUTOREPEAT_EN
    localparam int EXP_REPS      = 3;
    localparam int EXP_FIRST_REP = 15;
`else
    localparam int EXP_REPS      = 0;
    localparam int EXP_FIRST_REP = -1;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        tick_idx = 0; n_short = 0; n_long = 0; n_rep = 0; n_held_hi = 0; n_multi = 0;
        first_long_at = -1; first_rep_at = -1; first_short_at = -1;
        held_at_long = 1'b0;
    endtask

    // Advance n cycles, tallying outputs sampled 1 time unit after each edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            tick_idx++;
            if (short_p) begin
                n_short++;
                if (first_short_at < 0) first_short_at = tick_idx;
            end
            if (long_p) begin
                n_long++;
                if (first_long_at < 0) begin
                    first_long_at = tick_idx;
                    held_at_long  = held;
                end
            end
            if (repeat_p) begin
                n_rep++;
                if (first_rep_at < 0) first_rep_at = tick_idx;
            end
            if (held) n_held_hi++;
            if (int'(short_p) + int'(long_p) + int'(repeat_p) > 1) n_multi++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; debkey = 1'b1;
        repeat (3) tick();
        total_cnt++;
        if ({short_p, long_p, repeat_p, held} !== 4'b0000) $display("FAIL reset_outputs got=%b want=0000", {short_p, long_p, repeat_p, held});
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== KEY_IDLE) $display("FAIL reset_state got=%0d want=%0d", dut.state_q, KEY_IDLE);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        total_cnt++;
        if (dut.state_q !== KEY_PRESS) $display("FAIL press_after_reset got=%0d want=%0d", dut.state_q, KEY_PRESS);
        else pass_cnt++;
        debkey = 1'b0;
        tick();
        total_cnt++;
        if (short_p !== 1'b1) $display("FAIL short_after_reset_press got=%b want=1", short_p);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_short_press();
        clear_counts();
        debkey = 1'b1;
        step(3);
        debkey = 1'b0;
        step(3);
        total_cnt++;
        if (n_short !== 1) $display("FAIL short_count got=%0d want=1", n_short);
        else pass_cnt++;
        total_cnt++;
        if (first_short_at !== 4) $display("FAIL short_latency got=%0d want=4", first_short_at);
        else pass_cnt++;
        total_cnt++;
        if (n_long + n_rep + n_held_hi !== 0) $display("FAIL short_no_other got=%0d want=0", n_long + n_rep + n_held_hi);
        else pass_cnt++;
    endtask

    task automatic test_long_hold();
        clear_counts();
        debkey = 1'b1;
        step(25);
        debkey = 1'b0;
        step(1);
        total_cnt++;
        if (held !== 1'b0) $display("FAIL held_after_release got=%b want=0", held);
        else pass_cnt++;
        step(2);
        total_cnt++;
        if (n_long !== 1) $display("FAIL long_count got=%0d want=1", n_long);
        else pass_cnt++;
        total_cnt++;
        if (first_long_at !== 11) $display("FAIL long_latency got=%0d want=11", first_long_at);
        else pass_cnt++;
        total_cnt++;
        if (held_at_long !== 1'b1) $display("FAIL held_with_long got=%b want=1", held_at_long);
        else pass_cnt++;
        total_cnt++;
        if (n_held_hi !== 15) $display("FAIL held_cycles got=%0d want=15", n_held_hi);
        else pass_cnt++;
        total_cnt++;
        if (n_rep !== EXP_REPS) $display("FAIL repeat_count got=%0d want=%0d", n_rep, EXP_REPS);
        else pass_cnt++;
        total_cnt++;
        if (first_rep_at !== EXP_FIRST_REP) $display("FAIL repeat_first got=%0d want=%0d", first_rep_at, EXP_FIRST_REP);
        else pass_cnt++;
        total_cnt++;
        if (n_short !== 0) $display("FAIL long_no_short got=%0d want=0", n_short);
        else pass_cnt++;
    endtask

    task automatic test_boundary();
        clear_counts();
        debkey = 1'b1;
        step(10);
        debkey = 1'b0;
        step(3);
        total_cnt++;
        if (n_short !== 1) $display("FAIL boundary_short got=%0d want=1", n_short);
        else pass_cnt++;
        total_cnt++;
        if (first_short_at !== 11) $display("FAIL boundary_short_at got=%0d want=11", first_short_at);
        else pass_cnt++;
        total_cnt++;
        if (n_long + n_held_hi !== 0) $display("FAIL boundary_no_long got=%0d want=0", n_long + n_held_hi);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_held();
        clear_counts();
        debkey = 1'b1;
        step(13);
        total_cnt++;
        if (held !== 1'b1) $display("FAIL held_before_reset got=%b want=1", held);
        else pass_cnt++;
        rst = 1'b1;
        tick();
        total_cnt++;
        if ({short_p, long_p, repeat_p, held} !== 4'b0000) $display("FAIL midreset_outputs got=%b want=0000", {short_p, long_p, repeat_p, held});
        else pass_cnt++;
        total_cnt++;
        if (dut.state_q !== KEY_IDLE) $display("FAIL midreset_state got=%0d want=%0d", dut.state_q, KEY_IDLE);
        else pass_cnt++;
        rst = 1'b0;
        debkey = 1'b0;
        clear_counts();
        step(5);
        total_cnt++;
        if (n_short + n_long + n_rep + n_held_hi !== 0) $display("FAIL midreset_no_event got=%0d want=0", n_short + n_long + n_rep + n_held_hi);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        clear_counts();
        debkey = 1'b1; step(2);
        debkey = 1'b0; step(1);
        debkey = 1'b1; step(2);
        debkey = 1'b0; step(2);
        total_cnt++;
        if (n_short !== 2) $display("FAIL back_to_back_shorts got=%0d want=2", n_short);
        else pass_cnt++;
        total_cnt++;
        if (n_multi !== 0) $display("FAIL pulse_overlap got=%0d want=0", n_multi);
        else pass_cnt++;
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_short_press();
        test_long_hold();
        test_boundary();
        test_reset_in_held();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_key_press_classifier
